// File: rtl/interrupt_controller_pkg.sv
// Shared constants and FSM encoding for the interrupt controller and its arbiter.
package interrupt_controller_pkg;

    localparam int          IRQ_MAX             = 8;
    localparam int          ID_W                = 3;
    localparam logic [31:0] DEFAULT_VECTOR_BASE = 32'h0000_0010;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SAFE = 3'd1,
        ST_ENTER     = 3'd2,
        ST_IN_ISR    = 3'd3,
        ST_EXIT      = 3'd4
    } irq_state_e;

endpackage

// File: rtl/interrupt_controller_arbiter.sv
// Winner select over masked pending lines: fixed priority (index 0 highest) or
// round-robin starting at i_Ptr with wrap-around.
module irq_priority_arbiter
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ = 4,
    parameter int RR_EN   = 0
) (
    input  logic [NUM_IRQ-1:0] i_Req,
    input  logic [ID_W-1:0]    i_Ptr,
    output logic [ID_W-1:0]    o_Id,
    output logic               o_Valid
);

    localparam int IW = ID_W + 1;

    logic [IW-1:0]   w_Idx;
    logic [ID_W-1:0] w_Id;
    logic            w_Found;

    always_comb begin
        w_Idx   = '0;
        w_Id    = '0;
        w_Found = 1'b0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            w_Idx = (RR_EN != 0) ? ({1'b0, i_Ptr} + IW'(k)) : IW'(k);
            if (w_Idx >= IW'(NUM_IRQ)) begin
                w_Idx = w_Idx - IW'(NUM_IRQ);
            end
            if (!w_Found && (|(i_Req & (NUM_IRQ'(1) << w_Idx)))) begin
                w_Found = 1'b1;
                w_Id    = w_Idx[ID_W-1:0];
            end
        end
    end

    assign o_Id    = w_Id;
    assign o_Valid = w_Found;

endmodule

// File: rtl/interrupt_controller.sv
// Edge-latched interrupt controller: waits for a pipeline-safe point, pulses
// flush/save-PC/ack for one cycle, and tracks a single non-nested handler.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int          NUM_IRQ       = 4,
    parameter logic [31:0] VECTOR_BASE   = DEFAULT_VECTOR_BASE,
    parameter int          VECTOR_STRIDE = 4,
    parameter int          RR_EN         = 0
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [NUM_IRQ-1:0] i_IrqReq,
    input  logic               i_MaskWe,
    input  logic [NUM_IRQ-1:0] i_MaskData,
    input  logic               i_IntEnSet,
    input  logic               i_IntEnClr,
    input  logic               i_BranchPending,
    input  logic               i_StallSignal,
    input  logic               i_RetiBit,
    output logic               o_InterruptSignal,
    output logic               o_SavePc,
    output logic [31:0]        o_VectorAddr,
    output logic [NUM_IRQ-1:0] o_IrqAck,
    output logic [2:0]         o_ActiveId,
    output logic               o_InIsr,
    output logic [NUM_IRQ-1:0] o_Pending
);

    irq_state_e         r_State, w_NextState;
    logic [NUM_IRQ-1:0] r_IrqPrev, r_Pending, r_Mask;
    logic [NUM_IRQ-1:0] w_Edge, w_Ack, w_MaskedPend, w_ActiveBit;
    logic               r_En, r_SavedEn;
    logic [ID_W-1:0]    r_RrPtr, r_ActiveId, w_ArbId, w_NextPtr;
    logic               w_ArbValid, w_Capture, w_Enter, w_ActivePend, w_Live;

    irq_priority_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .RR_EN   (RR_EN)
    ) u_arb (
        .i_Req   (w_MaskedPend),
        .i_Ptr   (r_RrPtr),
        .o_Id    (w_ArbId),
        .o_Valid (w_ArbValid)
    );

    assign w_Live       = ~i_Rst;
    assign w_Edge       = i_IrqReq & ~r_IrqPrev;
    assign w_MaskedPend = r_Pending & r_Mask;
    assign w_ActiveBit  = NUM_IRQ'(1) << r_ActiveId;
    assign w_ActivePend = |(w_MaskedPend & w_ActiveBit);
    assign w_Enter      = (r_State == ST_ENTER);
    assign w_Ack        = (w_Enter && w_Live) ? w_ActiveBit : '0;
    assign w_Capture    = (r_State == ST_IDLE) && r_En && w_ArbValid;
    assign w_NextPtr    = (r_ActiveId == ID_W'(NUM_IRQ - 1)) ? '0 : r_ActiveId + 1'b1;

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            ST_IDLE: begin
                if (w_Capture) w_NextState = ST_WAIT_SAFE;
            end
            ST_WAIT_SAFE: begin
                // A withdrawn request or a DI abandons the entry before any pulse.
                if (!r_En || !w_ActivePend) begin
                    w_NextState = ST_IDLE;
                end else if (!(i_BranchPending || i_StallSignal)) begin
                    w_NextState = ST_ENTER;
                end
            end
            ST_ENTER:  w_NextState = ST_IN_ISR;
            ST_IN_ISR: begin
                if (i_RetiBit) w_NextState = ST_EXIT;
            end
            ST_EXIT:   w_NextState = ST_IDLE;
            default:   w_NextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State    <= ST_IDLE;
            r_IrqPrev  <= '0;
            r_Pending  <= '0;
            r_Mask     <= '0;
            r_En       <= 1'b0;
            r_SavedEn  <= 1'b0;
            r_RrPtr    <= '0;
            r_ActiveId <= '0;
        end else begin
            r_State   <= w_NextState;
            r_IrqPrev <= i_IrqReq;
            r_Pending <= (r_Pending & ~w_Ack) | w_Edge;
            if (i_MaskWe) r_Mask <= i_MaskData;
            if (w_Capture) r_ActiveId <= w_ArbId;
            if (w_Enter) begin
                r_SavedEn <= r_En;
                r_En      <= 1'b0;
                r_RrPtr   <= w_NextPtr;
            end else if (r_State == ST_EXIT) begin
                // An EI/DI retiring alongside the exit beats the saved value.
                r_En <= i_IntEnClr ? 1'b0 : (i_IntEnSet ? 1'b1 : r_SavedEn);
            end else if (i_IntEnClr) begin
                r_En <= 1'b0;
            end else if (i_IntEnSet) begin
                r_En <= 1'b1;
            end
        end
    end

    assign o_InterruptSignal = w_Enter && w_Live;
    assign o_SavePc          = w_Enter && w_Live;
    assign o_IrqAck          = w_Ack;
    assign o_VectorAddr      = VECTOR_BASE + 32'(r_ActiveId) * 32'(VECTOR_STRIDE);
    assign o_ActiveId        = r_ActiveId;
    assign o_InIsr           = (r_State == ST_IN_ISR) && w_Live;
    assign o_Pending         = w_MaskedPend;

endmodule
